// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - memory-mapped fixed-priority nested interrupt controller
// Optional build macro: IRQ_ARB_SYNC_EN (two-flop synchronizer on each irq_src bit)
module irq_arbiter #(
    parameter int          N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = 32'h00007F40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [31:0]      PrAddr,
    input  logic [31:0]      PrWD,
    input  logic             PrWe,
    output logic [31:0]      PrRD,
    output logic             hit,
    output logic             irq_out
);

    localparam int         ID_W        = 5;
    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_ENABLE  = 3'd1;
    localparam logic [2:0] OFF_MODE    = 3'd2;
    localparam logic [2:0] OFF_CLAIM   = 3'd3;
    localparam logic [2:0] OFF_DONE    = 3'd4;
    localparam logic [2:0] OFF_INSERV  = 3'd5;

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] in_service;

    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] claim_sel;
    logic [N_SRC-1:0] complete_sel;
    logic [N_SRC-1:0] prio_ok;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] mode_to_level;
    logic [N_SRC-1:0] pending_next;
    logic [ID_W-1:0]  claim_id;
    logic [2:0]       offset;
    logic             wr;
    logic             blocked;
    logic             unused_addr_bits;

`ifdef IRQ_ARB_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    // Two-flop synchronizer for sources on foreign clock domains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = irq_src;
`endif

    // Byte-address decode; the low two address bits select nothing
    assign hit              = (PrAddr[31:5] == BASE_ADDR[31:5]);
    assign offset           = PrAddr[4:2];
    assign wr               = PrWe & hit;
    assign unused_addr_bits = ^PrAddr[1:0];
    assign edge_det         = s & ~prev;

    // Decode CLAIM/COMPLETE values into one-hot source selects
    always_comb begin
        claim_sel    = '0;
        complete_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_sel[i]    = wr && (offset == OFF_CLAIM) && (PrWD == 32'(i + 1)) && pending[i];
            complete_sel[i] = wr && (offset == OFF_DONE) && (PrWD == 32'(i + 1));
        end
    end

    // A source is priority-qualified only if it is above every in-service source
    always_comb begin
        prio_ok = '0;
        blocked = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked    = blocked | in_service[i];
            prio_ok[i] = ~blocked;
        end
    end

    assign eligible = pending & enable & prio_ok;
    assign irq_out  = |eligible;

    // Lowest eligible index wins; report it as ID+1, 0 when nothing is eligible
    always_comb begin
        claim_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                claim_id = ID_W'(i + 1);
            end
        end
    end

    // Edge bits latch until claimed (a fresh edge beats a claim); level bits follow the source
    always_comb begin
        mode_to_level = (wr && (offset == OFF_MODE)) ? (mode & ~PrWD[N_SRC-1:0]) : '0;
        pending_next  = (mode & ((pending & ~claim_sel) | edge_det)) | (~mode & s);
        pending_next  = pending_next & ~mode_to_level;
    end

    // Register block state and source history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            in_service <= '0;
        end else begin
            prev       <= s;
            pending    <= pending_next;
            in_service <= (in_service | claim_sel) & ~complete_sel;
            if (wr && (offset == OFF_ENABLE)) begin
                enable <= PrWD[N_SRC-1:0];
            end
            if (wr && (offset == OFF_MODE)) begin
                mode <= PrWD[N_SRC-1:0];
            end
        end
    end

    // Zero-latency read mux with no side effects
    always_comb begin
        PrRD = '0;
        if (hit) begin
            case (offset)
                OFF_PENDING: PrRD = 32'(pending);
                OFF_ENABLE:  PrRD = 32'(enable);
                OFF_MODE:    PrRD = 32'(mode);
                OFF_CLAIM:   PrRD = 32'(claim_id);
                OFF_INSERV:  PrRD = 32'(in_service);
                default:     PrRD = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - scoreboard bench for irq_arbiter
module tb_irq_arbiter;

    localparam int          N_SRC = 6;
    localparam logic [31:0] BASE  = 32'h00007F40;

    logic             clk;
    logic             reset;
    logic [N_SRC-1:0] irq_src;
    logic [31:0]      PrAddr;
    logic [31:0]      PrWD;
    logic             PrWe;
    logic [31:0]      PrRD;
    logic             hit;
    logic             irq_out;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    logic req;
    int   checks;
    int   failures;

    irq_arbiter #(.N_SRC(N_SRC), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrWe    (PrWe),
        .PrRD    (PrRD),
        .hit     (hit),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation each time a sample is presented
    always @(negedge clk) begin
        if (req) begin
            exp_t        it;
            logic [31:0] act;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                it = sb.pop_front();
                case (it.kind)
                    0:       act = PrRD;
                    1:       act = {31'b0, irq_out};
                    default: act = {31'b0, hit};
                endcase
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic present(input string name, input int kind, input logic [31:0] exp);
        exp_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        sb.push_back(it);
        req = 1'b1;
        @(negedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic chk_rd(input int off, input logic [31:0] exp, input string name);
        PrAddr = BASE + 32'(off);
        present(name, 0, exp);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        present(name, 1, {31'b0, exp});
    endtask

    task automatic chk_hit(input int off, input logic exp, input string name);
        PrAddr = BASE + 32'(off);
        present(name, 2, {31'b0, exp});
    endtask

    task automatic wr(input int off, input logic [31:0] data);
        PrAddr = BASE + 32'(off);
        PrWD   = data;
        PrWe   = 1'b1;
        @(posedge clk);
        #1;
        PrWe   = 1'b0;
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        @(posedge clk);
        #1;
        irq_src[idx] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        req      = 1'b0;
        reset    = 1'b1;
        irq_src  = '0;
        PrAddr   = '0;
        PrWD     = '0;
        PrWe     = 1'b0;
        idle(2);
        chk_irq(1'b0, "irq_in_reset");
        reset = 1'b0;
        idle(1);

        // Reset state of every offset
        for (int o = 0; o < 32; o += 4) chk_rd(o, 32'h0, $sformatf("reset_off_%0h", o));
        chk_irq(1'b0, "reset_irq");

        // Single edge request, claim
        wr(32'h04, 32'h3F);
        wr(32'h08, 32'h3F);
        chk_rd(32'h05, 32'h3F, "enable_lowbits_ignored");
        pulse(3);
        chk_rd(32'h00, 32'h08, "src3_pending");
        chk_irq(1'b1, "src3_irq");
        chk_rd(32'h0C, 32'd4, "src3_claim_rd");
        wr(32'h0C, 32'd4);
        chk_rd(32'h00, 32'h00, "src3_claimed_pending");
        chk_rd(32'h14, 32'h08, "src3_inservice");
        chk_irq(1'b0, "src3_claimed_irq");

        // Nesting
        pulse(5);
        chk_irq(1'b0, "src5_masked_irq");
        chk_rd(32'h00, 32'h20, "src5_pending");
        pulse(1);
        chk_irq(1'b1, "src1_preempt_irq");
        chk_rd(32'h0C, 32'd2, "src1_claim_rd");
        wr(32'h0C, 32'd2);
        chk_rd(32'h14, 32'h0A, "nested_inservice");
        chk_irq(1'b0, "nested_irq");
        wr(32'h10, 32'd2);
        chk_irq(1'b0, "complete2_irq");
        wr(32'h10, 32'd4);
        chk_rd(32'h0C, 32'd6, "after_complete_claim_rd");
        chk_irq(1'b1, "after_complete_irq");
        wr(32'h0C, 32'd6);
        wr(32'h10, 32'd6);
        chk_rd(32'h14, 32'h00, "cleanup_inservice");
        chk_rd(32'h00, 32'h00, "cleanup_pending");

        // Level mode on source 0
        wr(32'h08, 32'h3E);
        irq_src[0] = 1'b1;
        idle(1);
        chk_rd(32'h00, 32'h01, "level_pending");
        chk_rd(32'h0C, 32'd1, "level_claim_rd");
        wr(32'h0C, 32'd1);
        chk_rd(32'h00, 32'h01, "level_claimed_pending");
        chk_rd(32'h14, 32'h01, "level_inservice");
        chk_irq(1'b0, "level_claimed_irq");
        wr(32'h10, 32'd1);
        chk_irq(1'b1, "level_reassert_irq");
        irq_src[0] = 1'b0;
        idle(1);
        chk_rd(32'h00, 32'h00, "level_drop_pending");
        chk_irq(1'b0, "level_drop_irq");

        // Edge arriving in the same cycle as its claim
        pulse(2);
        chk_rd(32'h00, 32'h04, "src2_pending");
        idle(1);
        irq_src[2] = 1'b1;
        PrAddr = BASE + 32'h0C;
        PrWD   = 32'd3;
        PrWe   = 1'b1;
        @(posedge clk);
        #1;
        PrWe       = 1'b0;
        irq_src[2] = 1'b0;
        chk_rd(32'h14, 32'h04, "race_inservice");
        chk_rd(32'h00, 32'h04, "race_pending");
        wr(32'h10, 32'd3);
        chk_irq(1'b1, "race_repend_irq");
        wr(32'h0C, 32'd3);
        wr(32'h10, 32'd3);
        chk_rd(32'h00, 32'h00, "race_cleanup_pending");

        // Ignored writes
        pulse(4);
        wr(32'h0C, 32'd0);
        wr(32'h0C, 32'd7);
        chk_rd(32'h14, 32'h00, "claim_oor_inservice");
        chk_rd(32'h00, 32'h10, "claim_oor_pending");
        wr(32'h0C, 32'd5);
        wr(32'h0C, 32'd1);
        wr(32'h10, 32'd9);
        wr(32'h00, 32'h3F);
        wr(32'h14, 32'h00);
        wr(32'h20, 32'h00);
        wr(32'h24, 32'h00);
        chk_rd(32'h14, 32'h10, "ignored_inservice");
        chk_rd(32'h00, 32'h00, "ignored_pending");
        chk_rd(32'h04, 32'h3F, "ignored_enable");
        chk_hit(32'h20, 1'b0, "hit_outside");
        chk_hit(32'h1C, 1'b1, "hit_top");
        chk_rd(32'h24, 32'h00, "rd_outside");

        idle(2);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
